// File: rtl/aska_hbridge_drv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aska_pkg
// Description : Shared state encodings and parameter defaults for the ASKA
//               H-bridge gate driver.
// Revision    : 1.0 - initial release
// ============================================================================
package aska_pkg;

    localparam int N_EL_DEF        = 4;
    localparam int WDOG_CYCLES_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        DRIVE = 3'd2,
        DISCH = 3'd3,
        FAULT = 3'd4
    } state_t;

endpackage : aska_pkg
`default_nettype wire

// File: rtl/aska_hbridge_drv_if.sv
`default_nettype none
// ============================================================================
// Interface   : aska_hbridge_drv_if
// Description : Request/acknowledge and gate-enable bundle between the ASKA
//               pulse generator (master) and the H-bridge driver (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface aska_hbridge_drv_if #(
    parameter int N_EL = 4,
    parameter int DT_W = 3
);
    logic [N_EL-1:0] up_req;
    logic [N_EL-1:0] down_req;
    logic [DT_W-1:0] dead_time;
    logic            fault_clr;
    logic [N_EL-1:0] up_drv;
    logic [N_EL-1:0] down_drv;
    logic            discharge;
    logic            fault;
    logic            busy;

    modport master (
        output up_req, down_req, dead_time, fault_clr,
        input  up_drv, down_drv, discharge, fault, busy
    );

    modport slave (
        input  up_req, down_req, dead_time, fault_clr,
        output up_drv, down_drv, discharge, fault, busy
    );
endinterface : aska_hbridge_drv_if
`default_nettype wire

// File: rtl/aska_hbridge_drv_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : aska_sat_counter
// Description : Up-counter with synchronous clear that holds at all-ones
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module aska_sat_counter #(
    parameter int W = 3
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    input  wire logic         i_clr,
    input  wire logic         i_inc,
    output logic [W-1:0]      o_cnt
);
    logic [W-1:0] r_cnt;

    // Clear wins over increment; increment stops at the top value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                      r_cnt <= '0;
        else if (i_clr)                   r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))  r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule : aska_sat_counter
`default_nettype wire

// File: rtl/aska_hbridge_drv.sv
`default_nettype none
// ============================================================================
// Module      : aska_hbridge_drv
// Description : H-bridge gate driver. Registers pulse-generator switch
//               requests, inserts break-before-make dead time, faults on
//               shoot-through requests or excessive on-time, and holds the
//               fault until acknowledged with no requests active.
//               Optional macro ASKA_HBRIDGE_DISCHARGE_EN adds a DISCH state
//               that closes all low-side switches after each pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module aska_hbridge_drv
    import aska_pkg::*;
#(
    parameter int N_EL         = N_EL_DEF,
    parameter int DT_W         = 3,
    parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF,
    parameter int DISCH_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    aska_hbridge_drv_if.slave bus
);
    localparam int DISCH_W = $clog2(DISCH_CYCLES + 1);
    localparam int CNT_W   = (DT_W > DISCH_W) ? DT_W : DISCH_W;
    localparam int WD_W    = $clog2(WDOG_CYCLES + 1);

    state_t          r_state, w_state_nx;
    logic [N_EL-1:0] r_up_q, r_down_q, r_up_tgt, r_down_tgt;
    logic [N_EL-1:0] r_up_drv, r_down_drv;
    logic            r_fault;
    logic [CNT_W-1:0] w_cnt;
    logic [WD_W-1:0]  w_wd;
    logic            w_cnt_clr, w_cnt_inc, w_wd_clr, w_wd_inc, w_tgt_load;
    logic            w_conflict, w_req_zero, w_req_chg, w_dt_done, w_wd_done;

    // Input register: every decision is made on the previous cycle's request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_up_q   <= '0;
            r_down_q <= '0;
        end else begin
            r_up_q   <= bus.up_req;
            r_down_q <= bus.down_req;
        end
    end

    assign w_conflict = |(r_up_q & r_down_q);
    assign w_req_zero = ~|{r_up_q, r_down_q};
    assign w_req_chg  = {r_up_q, r_down_q} != {r_up_tgt, r_down_tgt};
    assign w_dt_done  = (w_cnt == CNT_W'(bus.dead_time));
    assign w_wd_done  = (w_wd == WD_W'(WDOG_CYCLES - 1));

    // Next-state decode; branch order encodes event priority.
    always_comb begin
        w_state_nx = r_state;
        w_tgt_load = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_conflict) w_state_nx = FAULT;
                else if (!w_req_zero) begin
                    w_state_nx = DEAD;
                    w_tgt_load = 1'b1;
                    w_cnt_clr  = 1'b1;
                end
            end
            DEAD: begin
                if (w_conflict)      w_state_nx = FAULT;
                else if (w_req_zero) w_state_nx = IDLE;
                else if (w_req_chg) begin
                    w_tgt_load = 1'b1;
                    w_cnt_clr  = 1'b1;
                end
                else if (w_dt_done)  w_state_nx = DRIVE;
                else                 w_cnt_inc  = 1'b1;
            end
            DRIVE: begin
                if (w_conflict)      w_state_nx = FAULT;
                else if (w_wd_done)  w_state_nx = FAULT;
                else if (w_req_zero) begin
`ifdef ASKA_HBRIDGE_DISCHARGE_EN
                    w_state_nx = DISCH;
                    w_cnt_clr  = 1'b1;
`else
                    w_state_nx = IDLE;
`endif
                end
                else if (w_req_chg) begin
                    w_state_nx = DEAD;
                    w_tgt_load = 1'b1;
                    w_cnt_clr  = 1'b1;
                end
            end
`ifdef ASKA_HBRIDGE_DISCHARGE_EN
            DISCH: begin
                if (w_conflict) w_state_nx = FAULT;
                else if (!w_req_zero) begin
                    w_state_nx = DEAD;
                    w_tgt_load = 1'b1;
                    w_cnt_clr  = 1'b1;
                end
                else if (w_cnt == CNT_W'(DISCH_CYCLES - 1)) w_state_nx = IDLE;
                else w_cnt_inc = 1'b1;
            end
`endif
            FAULT: begin
                if (bus.fault_clr && w_req_zero) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Watchdog runs only while DRIVE is held; any exit resets it.
    assign w_wd_inc = (r_state == DRIVE) && (w_state_nx == DRIVE);
    assign w_wd_clr = !w_wd_inc;

    aska_sat_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_cnt)
    );

    aska_sat_counter #(.W(WD_W)) u_wd (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (w_wd_clr),
        .i_inc  (w_wd_inc),
        .o_cnt  (w_wd)
    );

    // State, target and gate outputs, all decoded from the next state so
    // outputs change on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_up_tgt   <= '0;
            r_down_tgt <= '0;
            r_up_drv   <= '0;
            r_down_drv <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_tgt_load) begin
                r_up_tgt   <= r_up_q;
                r_down_tgt <= r_down_q;
            end
            r_up_drv   <= (w_state_nx == DRIVE) ? r_up_tgt : '0;
            r_down_drv <= (w_state_nx == DRIVE) ? r_down_tgt :
                          (w_state_nx == DISCH) ? '1 : '0;
            r_fault    <= (w_state_nx == FAULT);
        end
    end

`ifdef ASKA_HBRIDGE_DISCHARGE_EN
    logic r_discharge;

    // Discharge flag tracks DISCH occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_discharge <= 1'b0;
        else         r_discharge <= (w_state_nx == DISCH);
    end

    assign bus.discharge = r_discharge;
`else
    assign bus.discharge = 1'b0;
`endif

    assign bus.up_drv   = r_up_drv;
    assign bus.down_drv = r_down_drv;
    assign bus.fault    = r_fault;
    assign bus.busy     = (r_state != IDLE);
endmodule : aska_hbridge_drv
`default_nettype wire

// File: doc/aska_hbridge_drv.md
Name: aska_hbridge_drv

Overview:
- Output stage directly downstream of the ASKA neurostimulation pulse generator.
- Consumes its raw up_switches/down_switches requests and drives the electrode H-bridge gate enables with break-before-make dead time.
- Detects illegal shoot-through requests and enforces a maximum continuous on-time watchdog.
- Latches faults until software clears them.

Parameters:
- N_EL, 4: number of electrodes (width of each switch vector).
- DT_W, 3: width of dead_time input.
- WDOG_CYCLES, 8: maximum consecutive DRIVE cycles with an unchanged target before a fault is raised.
- DISCH_CYCLES, 2: discharge duration in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; one clock domain.
- resetn  in  1  asynchronous, active-low reset.
- up_req  in  N_EL  requested high-side switches, from the pulse generator.
- down_req  in  N_EL  requested low-side switches, from the pulse generator.
- dead_time  in  DT_W  break-before-make gap, in cycles.
- fault_clr  in  1  level-sensitive fault acknowledge.
- up_drv  out  N_EL  high-side gate enables, registered.
- down_drv  out  N_EL  low-side gate enables, registered.
- discharge  out  1  electrode discharge active, registered.
- fault  out  1  latched fault flag, registered.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, resetn=0): all outputs 0; state IDLE; input register, target register and counters cleared. Reset mid-pulse opens all switches immediately, with no dead time applied.
- Input stage: {up_req, down_req} is registered every cycle into req_q. All decisions use req_q.
- conflict = |(up_q & down_q). Conflict is checked in every state except FAULT and has priority over all other transitions.
- States:
  - IDLE: outputs 0. If conflict, go to FAULT. If req_q is nonzero, latch target=req_q, clear cnt, go to DEAD.
  - DEAD: outputs 0.
    - req_q==0: go to IDLE.
    - req_q != target: relatch target, clear cnt, stay in DEAD.
    - cnt==dead_time: go to DRIVE with outputs = target.
    - Otherwise cnt+1.
    - DEAD therefore lasts dead_time+1 cycles; with dead_time=0 it lasts 1 cycle.
  - DRIVE: outputs = target; wd counts consecutive DRIVE cycles.
    - req_q==0: go to IDLE, outputs 0 on the same edge.
    - req_q != target (for example a polarity swap): outputs 0, relatch target, go to DEAD. Switching never goes directly from one nonzero pattern to another.
    - wd reaches WDOG_CYCLES: go to FAULT.
  - FAULT: outputs 0, fault=1. Go to IDLE only when fault_clr=1 and req_q==0. fault_clr while requests are active has no effect.
- Latency: a request that changes before edge k reaches the outputs after edge k+dead_time+2.
- Output removal: a request that drops before edge k is removed after edge k+1.
- Simultaneous events, highest priority first: conflict, then watchdog, then request change, then dead-time expiry.
- Counters saturate and never wrap.
- wd is cleared on any exit from DRIVE.
- dead_time is sampled at each comparison; changing it during DEAD takes effect on the next comparison.

Optional Feature:
- Macro: ASKA_HBRIDGE_DISCHARGE_EN.
- When defined:
  - A DRIVE-to-IDLE exit goes through a DISCH state instead of directly to IDLE.
  - DISCH: up_drv=0, down_drv=all ones, discharge=1, for DISCH_CYCLES cycles, then IDLE.
  - A nonzero req_q during DISCH goes to DEAD, so the down switches open before any new drive.
  - A conflict during DISCH goes to FAULT.
- When not defined: no DISCH state exists and discharge is tied to 0.

Decomposition:
- Shared package aska_pkg holds:
  - state encodings: IDLE, DEAD, DRIVE, DISCH, FAULT;
  - the N_EL default;
  - the WDOG_CYCLES default.
- One natural sub-module: aska_sat_counter, a parameterised saturating counter with clear, used for both cnt and wd.

Test Plan:
- Reset: with up_req=4'b0001 applied, pulse resetn low → all outputs 0 asynchronously. After release, IDLE with busy=0.
- Dead time 2: up_req=0001, down_req=0010 applied before edge 0 → up_drv=0001, down_drv=0010 after edge 4, and not earlier.
- Polarity swap: while driving 0001/0010, change to 0010/0001 → one edge with outputs 0, then 3 dead cycles (dead_time=2), then the swapped drive. No cycle has both patterns.
- Conflict: up_req=0011, down_req=0010 → fault=1, outputs 0. fault_clr with requests held has no effect. After requests drop to 0, fault_clr → IDLE, fault=0.
- Watchdog: with WDOG_CYCLES=8, hold 0001/0010 for 12 cycles → FAULT after 8 DRIVE cycles, outputs 0.
- With ASKA_HBRIDGE_DISCHARGE_EN: after a pulse ends, down_drv=1111 and discharge=1 for 2 cycles, then IDLE. A request arriving during DISCH goes through DEAD first.
